// File: rtl/lsu_axi_bridge_pkg.sv
// Shared definitions for the LSU-to-AXI4-Lite bridge: FSM encoding,
// AXI response codes and the fill pattern returned on a timed-out beat.
package lsu_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;

  localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;

  // AXI4-Lite has no exclusive access, so anything but OKAY is reported as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != AXI_RESP_OKAY);
  endfunction

endpackage

// File: rtl/lsu_axi_bridge_timeout_ctr.sv
// Saturating cycle counter that flags when an outstanding AXI beat has waited TIMEOUT cycles.
// TIMEOUT = 0 keeps expired_o low forever.
module axi_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT == 32'd0) ? 1 : $clog2(TIMEOUT + 32'd1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = (TIMEOUT != 32'd0) && (cnt_q == LIMIT);

  // Next count: clear wins, then count up until the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lsu_axi_bridge.sv
// Turns each LSU memory request into a single AXI4-Lite read or write transaction,
// one outstanding at a time, with a one-cycle completion pulse carrying data and error.
module lsu_axi_bridge
  import lsu_axi_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        armed_q, armed_d;
  logic        ctr_en_s;
  logic        ctr_clr_s;
  logic        tmo_expired_s;

  assign ctr_en_s  = (state_q == ST_WRITE) || (state_q == ST_WRESP) ||
                     (state_q == ST_READ)  || (state_q == ST_RDATA);
  assign ctr_clr_s = (state_q == ST_IDLE);

  axi_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk_i     (clock),
    .rst_ni    (reset),
    .clr_i     (ctr_clr_s),
    .en_i      (ctr_en_s),
    .expired_o (tmo_expired_s)
  );

  // Next-state, channel handshakes, capture and completion logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    armed_d      = armed_q;

    // Re-arm only once the LSU has withdrawn the previous request.
    if (!req_valid) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid && armed_q) begin
          addr_d  = req_addr;
          size_d  = req_size;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          if (req_wen) begin
            state_d   = ST_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_READ;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (awready) awvalid_d = 1'b0; else awvalid_d = awvalid_q;
        if (wready)  wvalid_d  = 1'b0; else wvalid_d  = wvalid_q;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = ST_WRESP;
          bready_d = 1'b1;
        end else begin
          state_d  = ST_WRITE;
        end
      end
      ST_WRESP: begin
        if (bvalid) begin
          bready_d     = 1'b0;
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = resp_is_err(bresp);
        end else begin
          state_d = ST_WRESP;
        end
      end
      ST_READ: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_RDATA: begin
        if (rvalid) begin
          rready_d     = 1'b0;
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = resp_is_err(rresp);
          resp_rdata_d = rdata;
        end else begin
          state_d = ST_RDATA;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        armed_d = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase

    // An expired beat is abandoned: a late B/R is ignored because ready is low.
    if (ctr_en_s && tmo_expired_s) begin
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      bready_d     = 1'b0;
      arvalid_d    = 1'b0;
      rready_d     = 1'b0;
      state_d      = ST_DONE;
      resp_valid_d = 1'b1;
      resp_err_d   = 1'b1;
      resp_rdata_d = TIMEOUT_FILL;
    end else begin
      resp_rdata_d = resp_rdata_d;
    end
  end

  // State and output registers; reset abandons any outstanding beat.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= 32'd0;
      size_q       <= 2'd0;
      wdata_q      <= 32'd0;
      wmask_q      <= 4'd0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      armed_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      armed_q      <= armed_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign awvalid    = awvalid_q;
  assign awaddr     = addr_q;
  assign awsize     = {1'b0, size_q};
  assign wvalid     = wvalid_q;
  assign wdata      = wdata_q;
  assign wstrb      = wmask_q;
  assign bready     = bready_q;
  assign arvalid    = arvalid_q;
  assign araddr     = addr_q;
  assign arsize     = {1'b0, size_q};
  assign rready     = rready_q;

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Directed bench for lsu_axi_bridge: a table of zero-wait transactions plus
// hand-written sequences for channel ordering, re-issue guard, timeout and reset.
module tb_lsu_axi_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  lsu_axi_bridge #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size), .req_wen(req_wen),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdat;
    logic [3:0]  wmask;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
  endtask

  // Ticks until resp_valid is seen (lat = ticks taken, -1 if budget expires).
  task automatic wait_resp(input int budget, output int lat, output int arv_cnt);
    lat = -1;
    arv_cnt = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (arvalid) arv_cnt++;
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic set_req(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wd, input logic [3:0] wm);
    req_wen = wen; req_addr = addr; req_size = size; req_wdata = wd; req_wmask = wm;
    req_valid = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int lat, arv;
    set_req(v.wen, v.addr, v.size, v.wdat, v.wmask);
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    bvalid = 1'b1; bresp = v.s_resp;
    rvalid = 1'b1; rdata = v.s_rdata; rresp = v.s_resp;
    tick();
    if (v.wen) begin
      check("vec_awvalid", {31'd0, awvalid}, 32'd1);
      check("vec_wvalid", {31'd0, wvalid}, 32'd1);
      check("vec_awaddr", awaddr, v.addr);
      check("vec_awsize", {29'd0, awsize}, {30'd0, v.size});
      check("vec_wdata", wdata, v.wdat);
      check("vec_wstrb", {28'd0, wstrb}, {28'd0, v.wmask});
    end else begin
      check("vec_arvalid", {31'd0, arvalid}, 32'd1);
      check("vec_araddr", araddr, v.addr);
      check("vec_arsize", {29'd0, arsize}, {30'd0, v.size});
    end
    wait_resp(8, lat, arv);
    check("vec_latency", 32'(lat + 1), 32'd3);
    check("vec_rdata", resp_rdata, v.exp_rdata);
    check("vec_err", {31'd0, resp_err}, {31'd0, v.exp_err});
    req_valid = 1'b0;
    slave_idle();
    tick();
    check("vec_pulse_end", {30'd0, resp_valid, resp_err}, 32'd0);
    tick();
  endtask

  initial begin
    int lat, arv;

    vecs[0] = '{1'b0, 32'h8000_0004, 2'd2, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0102, 2'd1, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b10, 32'hCAFE_F00D, 1'b1};
    vecs[2] = '{1'b0, 32'h0000_0010, 2'd0, 32'h0, 4'h0, 32'h0000_00A5, 2'b00, 32'h0000_00A5, 1'b0};
    vecs[3] = '{1'b1, 32'h4000_0008, 2'd2, 32'h1122_3344, 4'hF, 32'h0, 2'b00, 32'h0000_00A5, 1'b0};
    vecs[4] = '{1'b1, 32'h4000_0001, 2'd0, 32'h0000_AA00, 4'b0010, 32'h0, 2'b11, 32'h0000_00A5, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_0200, 2'd2, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b01, 32'h0BAD_F00D, 1'b1};

    reset = 1'b0;
    req_valid = 1'b0; req_addr = 32'd0; req_size = 2'd0; req_wen = 1'b0;
    req_wdata = 32'd0; req_wmask = 4'd0;
    slave_idle();
    repeat (3) tick();
    check("rst_valids", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    check("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    reset = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Store where W completes two cycles before AW.
    set_req(1'b1, 32'h4000_0100, 2'd2, 32'h0000_AB00, 4'b0010);
    tick();
    check("wf_wstrb", {28'd0, wstrb}, 32'h2);
    check("wf_wdata", wdata, 32'h0000_AB00);
    wready = 1'b1;
    tick();
    check("wf_w_dropped", {30'd0, awvalid, wvalid}, 32'h2);
    wready = 1'b0;
    tick();
    check("wf_aw_held", {30'd0, awvalid, wvalid}, 32'h2);
    check("wf_no_bready", {31'd0, bready}, 32'd0);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    check("wf_aw_dropped", {31'd0, awvalid}, 32'd0);
    check("wf_bready", {31'd0, bready}, 32'd1);
    check("wf_no_early_resp", {31'd0, resp_valid}, 32'd0);
    bvalid = 1'b1;
    tick();
    check("wf_resp", {30'd0, resp_valid, resp_err}, 32'h2);
    bvalid = 1'b0;
    req_valid = 1'b0;
    tick();
    check("wf_single_pulse", {31'd0, resp_valid}, 32'd0);
    tick();

    // Re-issue guard: request held high after its completion.
    set_req(1'b0, 32'h0000_0020, 2'd2, 32'd0, 4'd0);
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h5555_AAAA; awready = 1'b1; wready = 1'b1;
    tick();
    wait_resp(8, lat, arv);
    check("guard_latency", 32'(lat + 1), 32'd3);
    check("guard_rdata", resp_rdata, 32'h5555_AAAA);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("guard_no_reissue", {29'd0, arvalid, awvalid, resp_valid}, 32'd0);
    end
    req_valid = 1'b0;
    tick();
    check("guard_low", {31'd0, arvalid}, 32'd0);
    req_valid = 1'b1;
    tick();
    check("guard_rearmed", {31'd0, arvalid}, 32'd1);
    wait_resp(8, lat, arv);
    check("guard_second_latency", 32'(lat + 1), 32'd3);
    req_valid = 1'b0;
    slave_idle();
    repeat (2) tick();

    // Timeout: AR is never accepted.
    set_req(1'b0, 32'h0000_0300, 2'd2, 32'd0, 4'd0);
    tick();
    check("tmo_arvalid", {31'd0, arvalid}, 32'd1);
    wait_resp(30, lat, arv);
    check("tmo_latency", 32'(lat + 1), 32'd10);
    check("tmo_arvalid_cycles", 32'(arv + 1), 32'd9);
    check("tmo_err", {31'd0, resp_err}, 32'd1);
    check("tmo_rdata", resp_rdata, 32'hDEAD_BEEF);
    check("tmo_dropped", {30'd0, arvalid, rready}, 32'd0);
    req_valid = 1'b0;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h1111_2222;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("tmo_late_ignored", {30'd0, resp_valid, arvalid}, 32'd0);
    end
    check("tmo_rdata_hold", resp_rdata, 32'hDEAD_BEEF);
    slave_idle();
    tick();

    // Reset while waiting for B.
    set_req(1'b1, 32'h4000_0010, 2'd2, 32'h0000_0001, 4'hF);
    awready = 1'b1; wready = 1'b1;
    tick();
    tick();
    check("rw_bready", {31'd0, bready}, 32'd1);
    reset = 1'b0;
    req_valid = 1'b0;
    awready = 1'b0; wready = 1'b0;
    tick();
    check("rw_dropped", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    check("rw_state_idle", {29'd0, dut.state_q}, 32'd0);
    check("rw_rdata_clr", resp_rdata, 32'd0);
    reset = 1'b1;
    bvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rw_no_resp", {30'd0, resp_valid, bready}, 32'd0);
    end
    slave_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
